// File: rtl/lsu_load.sv
// Single-outstanding load unit in front of mem_read: aligns the address, extracts and extends the lane.
// Optional misalignment trap enabled by defining LSU_MISALIGN_CHECK_EN (adds the wb_misalign port).
module lsu_load #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_funct3,
    input  logic [4:0]        req_rd,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [4:0]        wb_rd,
`ifdef LSU_MISALIGN_CHECK_EN
    output logic              wb_misalign,
`endif
    output logic [31:0]       stall_cnt,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and payload is held stable while valid is high and ready is low.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [2:0]        off_q, off_d;
    logic [2:0]        f3_q, f3_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [31:0]       stall_q, stall_d;
    logic              req_mis;

    // Low offset bits below the access size simply drop out of the lane index.
    function automatic logic [63:0] extract(input logic [2:0] f3, input logic [2:0] off,
                                            input logic [63:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        logic [63:0] r;
        b = d[{off, 3'b000} +: 8];
        h = d[{off[2:1], 4'b0000} +: 16];
        w = d[{off[2], 5'b00000} +: 32];
        case (f3)
            3'b000:  r = {{56{b[7]}}, b};
            3'b001:  r = {{48{h[15]}}, h};
            3'b010:  r = {{32{w[31]}}, w};
            3'b100:  r = {56'd0, b};
            3'b101:  r = {48'd0, h};
            3'b110:  r = {32'd0, w};
            default: r = d;
        endcase
        return r;
    endfunction

`ifdef LSU_MISALIGN_CHECK_EN
    logic mis_q;

    always_comb begin
        req_mis = 1'b0;
        case (req_funct3[1:0])
            2'b01:   req_mis = req_addr[0];
            2'b10:   req_mis = |req_addr[1:0];
            2'b11:   req_mis = |req_addr[2:0];
            default: req_mis = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            mis_q <= 1'b0;
        end else if (state_q == S_IDLE && req_valid) begin
            mis_q <= req_mis;
        end
    end

    assign wb_misalign = mis_q;
`else
    assign req_mis = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        f3_d       = f3_q;
        mem_en_d   = mem_en_q;
        mem_addr_d = mem_addr_q;
        wb_valid_d = wb_valid_q;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        stall_d    = stall_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    off_d      = req_addr[2:0];
                    f3_d       = req_funct3;
                    wb_rd_d    = req_rd;
                    mem_addr_d = {req_addr[ADDR_W-1:3], 3'b000};
                    if (req_mis) begin
                        state_d    = S_RESP;
                        wb_valid_d = 1'b1;
                        wb_data_d  = '0;
                    end else begin
                        state_d  = S_WAIT;
                        mem_en_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                stall_d = stall_q + 32'd1;
                if (mem_valid) begin
                    state_d    = S_RESP;
                    mem_en_d   = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_data_d  = extract(f3_q, off_q, mem_rdata);
                end
            end
            S_RESP: begin
                // Acceptance returns to IDLE only; a new request waits for the next cycle.
                if (wb_ready) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q    <= S_IDLE;
            off_q      <= 3'd0;
            f3_q       <= 3'd0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= 5'd0;
            stall_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            f3_q       <= f3_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            stall_q    <= stall_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign mem_en    = mem_en_q;
    assign mem_addr  = mem_addr_q;
    assign wb_valid  = wb_valid_q;
    assign wb_data   = wb_data_q;
    assign wb_rd     = wb_rd_q;
    assign stall_cnt = stall_q;
    assign dbg_state = state_q;

endmodule
